// File: rtl/data_mem_responder_if.sv
// Data-port request/response bundle between the core-side requester and the memory responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        rd_wr;
  logic [1:0]  access_size;
  logic        resp_valid;
  logic [31:0] data_out;
  logic        resp_err;

  modport master (
    output req_valid, addr, data_in, rd_wr, access_size,
    input  req_ready, resp_valid, data_out, resp_err
  );

  modport slave (
    input  req_valid, addr, data_in, rd_wr, access_size,
    output req_ready, resp_valid, data_out, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-side memory responder: one request at a time, programmable wait states, big-endian
// byte storage mapped at MemStart, single-cycle response pulse with error flag.
module data_mem_responder #(
  parameter logic [31:0] MemStart = 32'h8002_0000,
  parameter int unsigned MemDepth = 1024,
  parameter int unsigned Latency  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  data_mem_responder_if.slave  dmem_io
);
  localparam int unsigned AddrW = $clog2(MemDepth);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        rd_q;
  logic [1:0]  size_q;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        resp_valid;

  logic [7:0]  mem_q [MemDepth];

  logic             accept, commit;
  logic [31:0]      offset, nbytes;
  logic             misaligned, in_range;
  logic [AddrW-1:0] idx;
  logic [31:0]      rd_word;

  assign accept = (state_q == StIdle) && dmem_io.req_valid && ready_q;
  // The WAIT->RESP edge is where the request takes architectural effect.
  assign commit = (state_q == StWait) && (cnt_q == 3'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StWait;
          cnt_d   = 3'(Latency);
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 3'd1;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ready is registered so it stays low in reset and rises on the first edge after release.
  always_comb begin
    ready_d    = (state_d == StIdle);
    resp_valid = (state_q == StResp);
  end

  assign dmem_io.req_ready  = ready_q;
  assign dmem_io.resp_valid = resp_valid;
  assign dmem_io.data_out   = rdata_q;
  assign dmem_io.resp_err   = err_q;

  always_comb begin
    offset = addr_q - MemStart;
    unique case (size_q)
      2'd0: begin nbytes = 32'd1; misaligned = 1'b0;          end
      2'd1: begin nbytes = 32'd2; misaligned = addr_q[0];     end
      2'd2: begin nbytes = 32'd4; misaligned = |addr_q[1:0];  end
      2'd3: begin nbytes = 32'd4; misaligned = 1'b1;          end
    endcase
    // Addresses below MemStart wrap to huge offsets and fail this unsigned compare.
    in_range = offset <= (32'(MemDepth) - nbytes);
    err_d    = misaligned || !in_range;
    idx      = offset[AddrW-1:0];
    rd_word  = {mem_q[idx], mem_q[idx + AddrW'(1)], mem_q[idx + AddrW'(2)],
                mem_q[idx + AddrW'(3)]};
    rdata_d  = 32'h0;
    if (rd_q && !err_d) begin
      unique case (size_q)
        2'd0:    rdata_d = {24'h0, rd_word[31:24]};
        2'd1:    rdata_d = {16'h0, rd_word[31:16]};
        default: rdata_d = rd_word;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 3'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= 1'b0;
      size_q  <= 2'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      if (accept) begin
        addr_q  <= dmem_io.addr;
        wdata_q <= dmem_io.data_in;
        rd_q    <= dmem_io.rd_wr;
        size_q  <= dmem_io.access_size;
      end
      if (commit) begin
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end

  // Storage is deliberately not reset; reset holds the FSM in IDLE so no commit can occur.
  always_ff @(posedge clk_i) begin
    if (commit && !rd_q && !err_d) begin
      unique case (size_q)
        2'd0: mem_q[idx] <= wdata_q[7:0];
        2'd1: begin
          mem_q[idx]              <= wdata_q[15:8];
          mem_q[idx + AddrW'(1)]  <= wdata_q[7:0];
        end
        default: begin
          mem_q[idx]              <= wdata_q[31:24];
          mem_q[idx + AddrW'(1)]  <= wdata_q[23:16];
          mem_q[idx + AddrW'(2)]  <= wdata_q[15:8];
          mem_q[idx + AddrW'(3)]  <= wdata_q[7:0];
        end
      endcase
    end
  end
endmodule
